du_dump_serializer: RTL and testbench

- Debug-unit back end that sits between the MIPS pipeline's debug taps and the UART transmitter.
- On a start request it captures the concatenated inter-stage latch snapshot (NB_R_INT bits) and then streams it as a framed byte sequence over a valid/ready byte interface to the UART TX FIFO.
- The stream continues with all register-file words (read via the pipeline's debug register port), then data-memory words (read via the debug memory port).
- Used after HALT and after every step in step mode.

---
 rtl/du_pkg.sv | 27 ++
 rtl/du_word_to_bytes.sv | 47 ++++
 rtl/du_dump_serializer.sv | 190 +++++++++++++++++++
 tb/tb_du_dump_serializer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/du_pkg.sv
// Shared types and constants for the debug-unit dump serializer.
package du_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StHeader,
    StLatch,
    StRegAddr,
    StRegWait,
    StRegSend,
    StMemAddr,
    StMemWait,
    StMemSend,
    StCksum,
    StDone
  } du_state_e;

  localparam logic [7:0]  HEADER           = 8'hA5;
  localparam int unsigned NB_R_INT_DEFAULT = 341;

  function automatic int unsigned latch_bytes(input int unsigned nb_r_int);
    return (nb_r_int + 7) / 8;
  endfunction

  localparam int unsigned LATCH_BYTES = latch_bytes(NB_R_INT_DEFAULT);

endpackage

// File: rtl/du_word_to_bytes.sv
// Splits a 32-bit word into four little-endian bytes over a valid/ready handshake.
module du_word_to_bytes (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        send_i,
  input  logic [31:0] word_i,
  input  logic        ready_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        last_o
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;
  logic        active_q;
  logic [31:0] word_cur;
  logic        xfer;

  // Byte 0 goes out straight from word_i in the load cycle, so no extra latency is added.
  always_comb begin
    word_cur = active_q ? word_q : word_i;
    byte_o   = word_cur[{cnt_q, 3'b000} +: 8];
    valid_o  = active_q | send_i;
    xfer     = valid_o & ready_i;
    last_o   = xfer & (cnt_q == 2'd3);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      if (send_i && !active_q) begin
        word_q   <= word_i;
        active_q <= 1'b1;
      end
      if (xfer) begin
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          active_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/du_dump_serializer.sv
// Streams a framed dump (header, latch snapshot, register file, data memory) as bytes.
// Define DU_DUMP_CHECKSUM_EN to append an XOR trailer byte covering the whole frame.
module du_dump_serializer
  import du_pkg::*;
#(
  parameter int unsigned NB_REG      = 32,
  parameter int unsigned NB_R_INT    = 341,
  parameter int unsigned N_REGS      = 32,
  parameter int unsigned MEM_WORDS   = 64,
  parameter int unsigned NB_MEM_ADDR = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic [NB_R_INT-1:0]    i_snapshot,
  output logic [4:0]             o_reg_addr,
  input  logic [NB_REG-1:0]      i_reg_data,
  output logic [NB_MEM_ADDR-1:0] o_mem_addr,
  input  logic [NB_REG-1:0]      i_mem_data,
  output logic [7:0]             o_byte,
  output logic                   o_byte_valid,
  input  logic                   i_byte_ready,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned LatchBytes = latch_bytes(NB_R_INT);
  localparam int unsigned SnapW      = LatchBytes * 8;
  localparam int unsigned IdxW       = $clog2(LatchBytes);

  du_state_e              state_q;
  logic [SnapW-1:0]       snap_q;
  logic [IdxW-1:0]        idx_q;
  logic [4:0]             reg_cnt_q;
  logic [4:0]             reg_addr_q;
  logic [NB_MEM_ADDR-1:0] mem_cnt_q;
  logic [NB_MEM_ADDR-1:0] mem_addr_q;
`ifdef DU_DUMP_CHECKSUM_EN
  logic [7:0]             cksum_q;
`endif

  logic        w2b_send;
  logic [31:0] w2b_word;
  logic [7:0]  w2b_byte;
  logic        w2b_valid;
  logic        w2b_last;
  logic        xfer;

  assign w2b_send = (state_q == StRegSend) || (state_q == StMemSend);
  assign w2b_word = (state_q == StMemSend) ? 32'(i_mem_data) : 32'(i_reg_data);

  du_word_to_bytes u_w2b (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .send_i  (w2b_send),
    .word_i  (w2b_word),
    .ready_i (i_byte_ready),
    .byte_o  (w2b_byte),
    .valid_o (w2b_valid),
    .last_o  (w2b_last)
  );

  always_comb begin
    o_byte       = '0;
    o_byte_valid = 1'b0;
    unique case (state_q)
      StHeader: begin
        o_byte       = HEADER;
        o_byte_valid = 1'b1;
      end
      StLatch: begin
        o_byte       = snap_q[7:0];
        o_byte_valid = 1'b1;
      end
      StRegSend, StMemSend: begin
        o_byte       = w2b_byte;
        o_byte_valid = w2b_valid;
      end
`ifdef DU_DUMP_CHECKSUM_EN
      StCksum: begin
        o_byte       = cksum_q;
        o_byte_valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign xfer       = o_byte_valid & i_byte_ready;
  assign o_busy     = (state_q != StIdle) && (state_q != StDone);
  assign o_done     = (state_q == StDone);
  assign o_reg_addr = reg_addr_q;
  assign o_mem_addr = mem_addr_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      snap_q     <= '0;
      idx_q      <= '0;
      reg_cnt_q  <= '0;
      reg_addr_q <= '0;
      mem_cnt_q  <= '0;
      mem_addr_q <= '0;
`ifdef DU_DUMP_CHECKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
`ifdef DU_DUMP_CHECKSUM_EN
      if (xfer) begin
        cksum_q <= cksum_q ^ o_byte;
      end
`endif
      unique case (state_q)
        StIdle, StDone: begin
          if (i_start) begin
            snap_q    <= SnapW'(i_snapshot);
            idx_q     <= '0;
            reg_cnt_q <= '0;
            mem_cnt_q <= '0;
`ifdef DU_DUMP_CHECKSUM_EN
            cksum_q   <= '0;
`endif
            state_q   <= StHeader;
          end else begin
            state_q <= StIdle;
          end
        end
        StHeader: begin
          if (i_byte_ready) begin
            state_q <= StLatch;
          end
        end
        StLatch: begin
          if (i_byte_ready) begin
            snap_q <= snap_q >> 8;
            idx_q  <= idx_q + 1'b1;
            if (idx_q == IdxW'(LatchBytes - 1)) begin
              state_q <= StRegAddr;
            end
          end
        end
        StRegAddr: begin
          reg_addr_q <= reg_cnt_q;
          state_q    <= StRegWait;
        end
        StRegWait: state_q <= StRegSend;
        StRegSend: begin
          if (w2b_last) begin
            if (reg_cnt_q == 5'(N_REGS - 1)) begin
              reg_cnt_q <= '0;
              state_q   <= StMemAddr;
            end else begin
              reg_cnt_q <= reg_cnt_q + 5'd1;
              state_q   <= StRegAddr;
            end
          end
        end
        StMemAddr: begin
          mem_addr_q <= mem_cnt_q;
          state_q    <= StMemWait;
        end
        StMemWait: state_q <= StMemSend;
        StMemSend: begin
          if (w2b_last) begin
            if (mem_cnt_q == NB_MEM_ADDR'(MEM_WORDS - 1)) begin
              mem_cnt_q <= '0;
`ifdef DU_DUMP_CHECKSUM_EN
              state_q   <= StCksum;
`else
              state_q   <= StDone;
`endif
            end else begin
              mem_cnt_q <= mem_cnt_q + 1'b1;
              state_q   <= StMemAddr;
            end
          end
        end
`ifdef DU_DUMP_CHECKSUM_EN
        StCksum: begin
          if (i_byte_ready) begin
            state_q <= StDone;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_du_dump_serializer.sv
// Self-checking bench: frame model built from queues, per-cycle compare, directed scenarios.
module tb_du_dump_serializer;

  localparam int unsigned NB_REG      = 32;
  localparam int unsigned NB_R_INT    = 341;
  localparam int unsigned N_REGS      = 32;
  localparam int unsigned MEM_WORDS   = 64;
  localparam int unsigned NB_MEM_ADDR = 8;
  localparam int unsigned LB          = (NB_R_INT + 7) / 8;
`ifdef DU_DUMP_CHECKSUM_EN
  localparam int unsigned CK = 1;
`else
  localparam int unsigned CK = 0;
`endif
  localparam int unsigned FRAME_LEN = 1 + LB + 4 * N_REGS + 4 * MEM_WORDS + CK;
  localparam int unsigned BUSY_CYC  = 1 + LB + 6 * (N_REGS + MEM_WORDS) + CK;

  logic                   i_clk = 1'b0;
  logic                   i_reset_n = 1'b0;
  logic                   i_start = 1'b0;
  logic [NB_R_INT-1:0]    i_snapshot = '0;
  logic [4:0]             o_reg_addr;
  logic [NB_REG-1:0]      i_reg_data = '0;
  logic [NB_MEM_ADDR-1:0] o_mem_addr;
  logic [NB_REG-1:0]      i_mem_data = '0;
  logic [7:0]             o_byte;
  logic                   o_byte_valid;
  logic                   i_byte_ready = 1'b0;
  logic                   o_busy;
  logic                   o_done;

  du_dump_serializer #(
    .NB_REG      (NB_REG),
    .NB_R_INT    (NB_R_INT),
    .N_REGS      (N_REGS),
    .MEM_WORDS   (MEM_WORDS),
    .NB_MEM_ADDR (NB_MEM_ADDR)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_start      (i_start),
    .i_snapshot   (i_snapshot),
    .o_reg_addr   (o_reg_addr),
    .i_reg_data   (i_reg_data),
    .o_mem_addr   (o_mem_addr),
    .i_mem_data   (i_mem_data),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (i_byte_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #10 i_clk = ~i_clk;

  logic [31:0] regs [N_REGS];
  logic [31:0] mems [MEM_WORDS];

  // Synchronous-read debug ports: data follows the address by one cycle.
  always @(posedge i_clk) begin
    i_reg_data <= regs[o_reg_addr];
    i_mem_data <= mems[o_mem_addr[5:0]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         busy_cyc = 0;
  int         done_cnt = 0;
  bit         toggle_mode = 1'b0;

  task automatic build_frame(input logic [NB_R_INT-1:0] snap);
    logic [LB*8-1:0] ps;
    logic [7:0]      x;
    exp_q.delete();
    rx_q.delete();
    busy_cyc = 0;
    ps = '0;
    ps[NB_R_INT-1:0] = snap;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < LB; k++) exp_q.push_back(ps[8*k +: 8]);
    for (int r = 0; r < N_REGS; r++)
      for (int b = 0; b < 4; b++) exp_q.push_back(regs[r][8*b +: 8]);
    for (int m = 0; m < MEM_WORDS; m++)
      for (int b = 0; b < 4; b++) exp_q.push_back(mems[m][8*b +: 8]);
    if (CK != 0) begin
      x = 8'h00;
      foreach (exp_q[i]) x = x ^ exp_q[i];
      exp_q.push_back(x);
    end
  endtask

  // Compare process: checks every accepted byte, hold behaviour, done and address stepping.
  bit         pv = 1'b0;
  logic [7:0] pb = '0;
  logic [4:0] last_ra = '0;
  int         ra_hold = 2;

  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      pv      = 1'b0;
      last_ra = '0;
      ra_hold = 2;
    end else begin
      if (pv) begin
        check("hold_valid", 32'(o_byte_valid), 32'd1);
        check("hold_byte", 32'(o_byte), 32'(pb));
      end
      if (o_busy) busy_cyc++;
      if (o_byte_valid && i_byte_ready) begin
        if (rx_q.size() < exp_q.size())
          check($sformatf("byte[%0d]", rx_q.size()), 32'(o_byte), 32'(exp_q[rx_q.size()]));
        else
          check("extra_byte", 32'(rx_q.size()), 32'(exp_q.size()));
        rx_q.push_back(o_byte);
      end
      pv = o_byte_valid && !i_byte_ready;
      pb = o_byte;
      if (o_done) begin
        done_cnt++;
        check("done_len", 32'(rx_q.size()), FRAME_LEN);
        check("done_busy", 32'(o_busy), 32'd0);
      end
      if (o_reg_addr != last_ra) begin
        check("reg_addr_step", 32'(o_reg_addr), 32'(5'(last_ra + 5'd1)));
        check("reg_addr_hold", 32'(ra_hold >= 2), 32'd1);
        last_ra = o_reg_addr;
        ra_hold = 1;
      end else begin
        ra_hold++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      i_byte_ready = toggle_mode ? ~i_byte_ready : 1'b1;
    end
  end

  task automatic start_frame(input logic [NB_R_INT-1:0] snap);
    build_frame(snap);
    i_snapshot = snap;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    check("first_valid", {23'd0, o_byte_valid, o_busy, o_byte}, {23'd0, 1'b1, 1'b1, 8'hA5});
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge i_clk);
      n++;
    end
    #1;
    if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_bytes(input int count, input int budget);
    int n;
    n = 0;
    while (rx_q.size() < count && n < budget) begin
      @(posedge i_clk);
      n++;
    end
    #1;
    if (rx_q.size() < count) check("byte_timeout", 32'(rx_q.size()), 32'(count));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int n = 0; n < N_REGS; n++) regs[n] = 32'h0100_0000 * n + n;
    for (int m = 0; m < MEM_WORDS; m++) mems[m] = m * 4;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_outs", {8'd0, o_byte, o_byte_valid, o_busy, o_done, o_reg_addr, o_mem_addr}, 32'd0);
    i_reset_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;

    // All-ones snapshot, ready held high.
    toggle_mode = 1'b0;
    start_frame({NB_R_INT{1'b1}});
    wait_done(2000);
    check("a_len", 32'(rx_q.size()), FRAME_LEN);
    check("a_busy_cycles", 32'(busy_cyc), BUSY_CYC);
    check("a_hdr", 32'(rx_q[0]), 32'hA5);
    check("a_latch0", 32'(rx_q[1]), 32'hFF);
    check("a_latch41", 32'(rx_q[42]), 32'hFF);
    check("a_latch_last", 32'(rx_q[43]), 32'h1F);
    check("a_reg0", {rx_q[44], rx_q[45], rx_q[46], rx_q[47]}, 32'h0000_0000);
    check("a_reg1", {rx_q[48], rx_q[49], rx_q[50], rx_q[51]}, 32'h0100_0001);
    check("a_reg_addr_last", 32'(o_reg_addr), 32'd31);

    // Ready toggling every cycle.
    toggle_mode = 1'b1;
    d0 = done_cnt;
    start_frame({11{31'h5A5A_1234}});
    wait_done(4000);
    check("b_done_once", 32'(done_cnt - d0), 32'd1);
    check("b_len", 32'(rx_q.size()), FRAME_LEN);
    check("b_last_word", {rx_q[FRAME_LEN-CK-4], rx_q[FRAME_LEN-CK-3], rx_q[FRAME_LEN-CK-2],
                          rx_q[FRAME_LEN-CK-1]}, 32'hFC00_0000);

    // Second start mid-frame must be ignored.
    toggle_mode = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    d0 = done_cnt;
    start_frame({11{31'h1357_2468}});
    wait_bytes(100, 1000);
    i_snapshot = '0;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_done(2000);
    repeat (50) @(posedge i_clk);
    #1;
    check("c_done_once", 32'(done_cnt - d0), 32'd1);
    check("c_len", 32'(rx_q.size()), FRAME_LEN);
    check("c_idle", {30'd0, o_busy, o_byte_valid}, 32'd0);

    // Reset mid-frame aborts; a fresh frame follows.
    start_frame({11{31'h0F0F_3C3C}});
    wait_bytes(200, 1000);
    d0 = done_cnt;
    i_reset_n = 1'b0;
    #1;
    check("d_reset_outs", {8'd0, o_byte, o_byte_valid, o_busy, o_done, o_reg_addr, o_mem_addr},
          32'd0);
    repeat (3) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    repeat (10) @(posedge i_clk);
    #1;
    check("d_no_done", 32'(done_cnt - d0), 32'd0);
    check("d_no_resume", {30'd0, o_busy, o_byte_valid}, 32'd0);
    start_frame({11{31'h2222_1111}});
    wait_done(2000);
    check("d_len", 32'(rx_q.size()), FRAME_LEN);
    check("d_hdr", 32'(rx_q[0]), 32'hA5);

`ifdef DU_DUMP_CHECKSUM_EN
    for (int n = 0; n < N_REGS; n++) regs[n] = '0;
    for (int m = 0; m < MEM_WORDS; m++) mems[m] = '0;
    repeat (2) @(posedge i_clk);
    #1;
    start_frame('0);
    wait_done(2000);
    check("e_len", 32'(rx_q.size()), 32'd429);
    check("e_trailer", 32'(rx_q[FRAME_LEN-1]), 32'hA5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
